// File: rtl/tristate_bus_ctrl.sv
// Sequencer for a shared tri-state data bus: single read/write transactions
// with registered strobes, output-enable and a turnaround gap after each one.
module tristate_bus_ctrl #(
    parameter int width     = 8,
    parameter int awidth    = 8,
    parameter int WR_CYCLES = 1,
    parameter int RD_WAIT   = 2,
    parameter int TA_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN_req,
    output logic              RDY_req,
    input  logic              req_write,
    input  logic [awidth-1:0] req_addr,
    input  logic [width-1:0]  req_wdata,
    input  logic              EN_resp,
    output logic              RDY_resp,
    output logic [width-1:0]  resp_data,
    output logic [awidth-1:0] BUS_ADDR,
    output logic              BUS_CS,
    output logic              BUS_WE,
    output logic [width-1:0]  BUS_OUT,
    output logic              BUS_OE,
    input  logic [width-1:0]  BUS_IN
);

    localparam int CMAX0 = (WR_CYCLES > RD_WAIT) ? WR_CYCLES : RD_WAIT;
    localparam int CMAX  = (CMAX0 > TA_CYCLES) ? CMAX0 : TA_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] TA_LOAD = CW'((TA_CYCLES > 0) ? TA_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          resp_hold;

    // Response still occupies the slot after this edge.
    assign resp_hold = RDY_resp && !EN_resp;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            RDY_req   <= 1'b1;
            RDY_resp  <= 1'b0;
            resp_data <= '0;
            BUS_ADDR  <= '0;
            BUS_CS    <= 1'b0;
            BUS_WE    <= 1'b0;
            BUS_OUT   <= '0;
            BUS_OE    <= 1'b0;
        end else begin
            if (RDY_resp && EN_resp)
                RDY_resp <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (EN_req && RDY_req) begin
                        RDY_req  <= 1'b0;
                        BUS_ADDR <= req_addr;
                        BUS_CS   <= 1'b1;
                        if (req_write) begin
                            state   <= WRITE;
                            cnt     <= WR_LOAD;
                            BUS_WE  <= 1'b1;
                            BUS_OE  <= 1'b1;
                            BUS_OUT <= req_wdata;
                        end else begin
                            state <= READ;
                            cnt   <= RD_LOAD;
                        end
                    end else begin
                        RDY_req <= !resp_hold;
                    end
                end

                WRITE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        BUS_CS <= 1'b0;
                        BUS_WE <= 1'b0;
                        BUS_OE <= 1'b0;
                        if (TA_CYCLES == 0) begin
                            state   <= IDLE;
                            RDY_req <= !resp_hold;
                        end else begin
                            state <= TURN;
                            cnt   <= TA_LOAD;
                        end
                    end
                end

                READ: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        BUS_CS    <= 1'b0;
                        resp_data <= BUS_IN;
                        RDY_resp  <= 1'b1;
                        if (TA_CYCLES == 0) begin
                            state   <= IDLE;
                            RDY_req <= 1'b0;
                        end else begin
                            state <= TURN;
                            cnt   <= TA_LOAD;
                        end
                    end
                end

                TURN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state   <= IDLE;
                        RDY_req <= !resp_hold;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Directed and randomized checks of tristate_bus_ctrl: default timing on
// one instance, zero-turnaround multi-cycle writes on a second.
module tb_tristate_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters
    logic       rst_a, en_req_a, rdy_req_a, req_write_a, en_resp_a, rdy_resp_a;
    logic [7:0] req_addr_a, req_wdata_a, resp_data_a;
    logic [7:0] addr_a, out_a, bus_in_a;
    logic       cs_a, we_a, oe_a;

    // Instance B: WR_CYCLES=3, TA_CYCLES=0
    logic       rst_b, en_req_b, rdy_req_b, req_write_b, en_resp_b, rdy_resp_b;
    logic [7:0] req_addr_b, req_wdata_b, resp_data_b;
    logic [7:0] addr_b, out_b, bus_in_b;
    logic       cs_b, we_b, oe_b;

    logic [7:0] dev_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_q [$];

    tristate_bus_ctrl dut_a (
        .CLK(clk), .RST(rst_a),
        .EN_req(en_req_a), .RDY_req(rdy_req_a),
        .req_write(req_write_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .EN_resp(en_resp_a), .RDY_resp(rdy_resp_a), .resp_data(resp_data_a),
        .BUS_ADDR(addr_a), .BUS_CS(cs_a), .BUS_WE(we_a),
        .BUS_OUT(out_a), .BUS_OE(oe_a), .BUS_IN(bus_in_a)
    );

    tristate_bus_ctrl #(.WR_CYCLES(3), .TA_CYCLES(0)) dut_b (
        .CLK(clk), .RST(rst_b),
        .EN_req(en_req_b), .RDY_req(rdy_req_b),
        .req_write(req_write_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .EN_resp(en_resp_b), .RDY_resp(rdy_resp_b), .resp_data(resp_data_b),
        .BUS_ADDR(addr_b), .BUS_CS(cs_b), .BUS_WE(we_b),
        .BUS_OUT(out_b), .BUS_OE(oe_b), .BUS_IN(bus_in_b)
    );

    // Device model on the A bus
    always @(posedge clk)
        if (cs_a && we_a && oe_a)
            dev_mem[addr_a] <= out_a;

    always_comb begin
        bus_in_a = 8'h00;
        if (cs_a && !we_a)
            bus_in_a = dev_mem[addr_a];
    end

    assign bus_in_b = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output enable may only be high while a write strobe is active
    always @(negedge clk) begin
        if (!rst_a)
            check("oe_impl_a", {31'd0, !oe_a || (cs_a && we_a)}, 32'd1);
        if (!rst_b)
            check("oe_impl_b", {31'd0, !oe_b || (cs_b && we_b)}, 32'd1);
    end

    logic [7:0] exp_oe;
    int         nreads;

    initial begin
        for (int i = 0; i < 256; i++)
            dev_mem[i] = 8'(i * 7 + 3);
        rst_a = 1'b1; rst_b = 1'b1;
        en_req_a = 0; req_write_a = 0; req_addr_a = 0; req_wdata_a = 0; en_resp_a = 0;
        en_req_b = 0; req_write_b = 0; req_addr_b = 0; req_wdata_b = 0; en_resp_b = 0;
        step();
        step();
        check("rst_cs", cs_a, 0);
        check("rst_we", we_a, 0);
        check("rst_oe", oe_a, 0);
        check("rst_rdy_resp", rdy_resp_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_out", out_a, 0);
        check("rst_rdata", resp_data_a, 0);
        check("rst_rdy_req", rdy_req_a, 1);
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // T2: write 0xA5 to 0x12
        en_req_a = 1; req_write_a = 1; req_addr_a = 8'h12; req_wdata_a = 8'hA5;
        step();
        en_req_a = 0;
        check("t2_cs", cs_a, 1);
        check("t2_we", we_a, 1);
        check("t2_oe", oe_a, 1);
        check("t2_out", out_a, 8'hA5);
        check("t2_addr", addr_a, 8'h12);
        check("t2_rdy_busy", rdy_req_a, 0);
        step();
        check("t2_turn_oe", oe_a, 0);
        check("t2_turn_cs", cs_a, 0);
        check("t2_turn_out", out_a, 8'hA5);
        check("t2_turn_addr", addr_a, 8'h12);
        check("t2_turn_rdy", rdy_req_a, 0);
        step();
        check("t2_rdy", rdy_req_a, 1);
        check("t2_devmem", dev_mem[8'h12], 8'hA5);

        // T3: read 0x40 returning 0x3C
        dev_mem[8'h40] = 8'h3C;
        en_req_a = 1; req_write_a = 0; req_addr_a = 8'h40;
        step();
        en_req_a = 0;
        check("t3_cs1", cs_a, 1);
        check("t3_we1", we_a, 0);
        check("t3_oe1", oe_a, 0);
        check("t3_addr", addr_a, 8'h40);
        step();
        check("t3_cs2", cs_a, 1);
        check("t3_resp_early", rdy_resp_a, 0);
        step();
        check("t3_cs3", cs_a, 0);
        check("t3_resp", rdy_resp_a, 1);
        check("t3_rdata", resp_data_a, 8'h3C);
        check("t3_rdy_req", rdy_req_a, 0);
        step();
        check("t3_rdy_req_idle", rdy_req_a, 0);

        // T4: request blocked by unconsumed response
        en_req_a = 1; req_write_a = 1; req_addr_a = 8'h55; req_wdata_a = 8'h77;
        step();
        check("t4_blk_cs", cs_a, 0);
        step();
        check("t4_blk_cs2", cs_a, 0);
        check("t4_blk_rdy", rdy_req_a, 0);
        en_resp_a = 1;
        step();
        en_resp_a = 0;
        check("t4_resp_clr", rdy_resp_a, 0);
        check("t4_rdata_hold", resp_data_a, 8'h3C);
        check("t4_rdy_req", rdy_req_a, 1);
        check("t4_still_idle", cs_a, 0);
        step();
        en_req_a = 0;
        check("t4_go_cs", cs_a, 1);
        check("t4_go_out", out_a, 8'h77);
        check("t4_go_addr", addr_a, 8'h55);
        step();
        step();
        check("t4_done_rdy", rdy_req_a, 1);

        // T1: reset in the middle of a 3-cycle write on B
        en_req_b = 1; req_write_b = 1; req_addr_b = 8'h09; req_wdata_b = 8'hC3;
        step();
        en_req_b = 0;
        check("t1_pre_oe", oe_b, 1);
        rst_b = 1;
        step();
        check("t1_oe", oe_b, 0);
        check("t1_cs", cs_b, 0);
        check("t1_rdy_req", rdy_req_b, 1);
        check("t1_rdy_resp", rdy_resp_b, 0);
        step();
        rst_b = 0;
        step();

        // T5: back-to-back 3-cycle writes with no turnaround
        exp_oe = 8'b0111_0111;
        en_req_b = 1; req_write_b = 1; req_addr_b = 8'h01; req_wdata_b = 8'h11;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4)
                en_req_b = 0;
            check($sformatf("t5_oe%0d", i), oe_b, exp_oe[i]);
            check($sformatf("t5_cs%0d", i), cs_b, exp_oe[i]);
        end
        check("t5_rdy_idle", rdy_req_b, 1);

        // T6: random mix against a reference memory
        for (int i = 0; i < 256; i++)
            ref_mem[i] = dev_mem[i];
        nreads = 0;
        for (int i = 0; i < 10000; i++) begin
            en_req_a    = ($urandom_range(0, 2) == 0);
            req_write_a = 1'($urandom_range(0, 1));
            req_addr_a  = 8'($urandom_range(0, 15));
            req_wdata_a = 8'($urandom);
            en_resp_a   = 1'($urandom_range(0, 1));
            if (en_req_a && rdy_req_a) begin
                if (req_write_a) begin
                    ref_mem[req_addr_a] = req_wdata_a;
                end else begin
                    exp_q.push_back(ref_mem[req_addr_a]);
                    nreads++;
                end
            end
            if (en_resp_a && rdy_resp_a) begin
                if (exp_q.size() == 0)
                    check("t6_spurious", 1, 0);
                else
                    check("t6_rdata", resp_data_a, exp_q.pop_front());
            end
            step();
        end
        en_req_a = 0;
        en_resp_a = 1;
        for (int i = 0; i < 20; i++) begin
            if (rdy_resp_a) begin
                if (exp_q.size() == 0)
                    check("t6_spurious", 1, 0);
                else
                    check("t6_rdata", resp_data_a, exp_q.pop_front());
            end
            step();
        end
        en_resp_a = 0;
        check("t6_drain", exp_q.size(), 0);
        check("t6_reads", {31'd0, nreads > 100}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
